// File: rtl/qdec_cabac_package.sv
// rtl/qdec_cabac_package.sv - shared CABAC decoder types and constants
package qdec_cabac_package;

    localparam int BSF_WORD_BYTES = 4;
    localparam int BSF_LEN_W      = 17;

    typedef enum logic [1:0] {
        BSF_IDLE  = 2'd0,
        BSF_FETCH = 2'd1,
        BSF_DRAIN = 2'd2,
        BSF_FLUSH = 2'd3
    } t_bsf_state_e;

endpackage

// File: rtl/basic_fifo.sv
// rtl/basic_fifo.sv - single-clock show-ahead FIFO with occupancy count
module basic_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_fire, rd_fire;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign wr_fire = wr_en && (count_q != CNT_W'(DEPTH));
    assign rd_fire = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_fire ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_fire ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_fire) - CNT_W'(rd_fire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/qdec_bs_fetch_ctrl.sv
// rtl/qdec_bs_fetch_ctrl.sv - credit-based word fetch and byte unpack into the CABAC bitstream port
module qdec_bs_fetch_ctrl
    import qdec_cabac_package::*;
#(
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int BUF_DEPTH       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [BSF_LEN_W-1:0] byte_len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [BSF_LEN_W-1:0] bytes_sent,
    output logic [ADDR_W-1:0]    mem_req_addr,
    output logic                 mem_req_vld,
    input  logic                 mem_req_rdy,
    input  logic [31:0]          mem_rsp_data,
    input  logic                 mem_rsp_vld,
    output logic [7:0]           bs_dout,
    output logic                 bs_dout_vld,
    input  logic                 bs_dout_rdy
);
    localparam int IDX_W   = $clog2(BSF_WORD_BYTES);
    localparam int WORDS_W = BSF_LEN_W - IDX_W;
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W   = $clog2(BUF_DEPTH + 1);

    t_bsf_state_e         state_q, state_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [BSF_LEN_W-1:0] len_q, len_d, bytes_sent_q, bytes_sent_d;
    logic [WORDS_W-1:0]   words_req_q, words_req_d, total_words;
    logic [OUT_W-1:0]     outstanding_q, outstanding_d;
    logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic                 done_q, done_d, error_q, error_d;
    logic                 pend_q, pend_d, armed_q, armed_d;

    logic                 active, issue_ok, req_fire, rsp_ok, fifo_wr, fifo_rd, fifo_empty;
    logic                 accept, last_byte, word_done, flush_pop, fifo_clear_next;
    logic [31:0]          head_word;
    logic [CNT_W-1:0]     buf_count;

    assign active      = (state_q == BSF_FETCH) || (state_q == BSF_DRAIN);
    assign total_words = WORDS_W'((len_q + BSF_LEN_W'(BSF_WORD_BYTES - 1)) >> IDX_W);

    // Credits count both in-flight words and buffered words, so every response has a slot.
    assign issue_ok = (words_req_q < total_words)
                   && ((32'(outstanding_q) + 32'(buf_count)) < 32'(BUF_DEPTH))
                   && (32'(outstanding_q) < 32'(MAX_OUTSTANDING));

    assign mem_req_vld  = ((state_q == BSF_FETCH) && issue_ok) || ((state_q == BSF_FLUSH) && pend_q);
    assign mem_req_addr = mem_req_vld ? base_q + ADDR_W'({words_req_q, {IDX_W{1'b0}}}) : '0;
    assign req_fire     = mem_req_vld && mem_req_rdy;

    assign rsp_ok  = mem_rsp_vld && (outstanding_q != '0);
    assign fifo_wr = rsp_ok && active && !abort;

    assign bs_dout_vld = active && !fifo_empty;
    assign bs_dout     = bs_dout_vld ? head_word[{byte_idx_q, 3'b000} +: 8] : 8'h00;
    assign accept      = bs_dout_vld && bs_dout_rdy;
    assign last_byte   = accept && ((bytes_sent_q + BSF_LEN_W'(1)) == len_q);
    assign word_done   = accept && ((byte_idx_q == IDX_W'(BSF_WORD_BYTES - 1)) || last_byte);

    // Abort clears the buffer by popping one entry per cycle until it is empty.
    assign flush_pop       = (state_q == BSF_FLUSH) && !fifo_empty;
    assign fifo_rd         = word_done || flush_pop;
    assign fifo_clear_next = (buf_count == '0) || ((buf_count == CNT_W'(1)) && fifo_rd);

    assign busy       = (state_q != BSF_IDLE);
    assign done       = done_q;
    assign error      = error_q;
    assign bytes_sent = bytes_sent_q;

    basic_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (BUF_DEPTH),
        .CNT_W      (CNT_W)
    ) u_word_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (mem_rsp_data),
        .rd_en   (fifo_rd),
        .rd_data (head_word),
        .empty   (fifo_empty),
        .count   (buf_count)
    );

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        bytes_sent_d  = bytes_sent_q;
        words_req_d   = words_req_q;
        byte_idx_d    = byte_idx_q;
        pend_d        = pend_q;
        armed_d       = armed_q;
        done_d        = 1'b0;
        // Stray responses left over from before a reset are not reported until a start is seen.
        error_d       = mem_rsp_vld && (outstanding_q == '0) && armed_q;
        outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(rsp_ok);
        if (req_fire) begin
            words_req_d = words_req_q + WORDS_W'(1);
        end
        if (accept) begin
            bytes_sent_d = bytes_sent_q + BSF_LEN_W'(1);
            byte_idx_d   = word_done ? '0 : byte_idx_q + IDX_W'(1);
        end
        unique case (state_q)
            BSF_IDLE: begin
                if (start) begin
                    armed_d = 1'b1;
                    if (base_addr[IDX_W-1:0] != '0) begin
                        error_d = 1'b1;
                    end else if (byte_len == '0) begin
                        done_d       = 1'b1;
                        bytes_sent_d = '0;
                    end else begin
                        base_d       = base_addr;
                        len_d        = byte_len;
                        bytes_sent_d = '0;
                        words_req_d  = '0;
                        byte_idx_d   = '0;
                        state_d      = BSF_FETCH;
                    end
                end
            end
            BSF_FETCH, BSF_DRAIN: begin
                if (abort) begin
                    state_d    = BSF_FLUSH;
                    pend_d     = mem_req_vld && !mem_req_rdy;
                    byte_idx_d = '0;
                end else if (last_byte) begin
                    done_d  = 1'b1;
                    state_d = BSF_IDLE;
                end else if ((state_q == BSF_FETCH) && req_fire && (words_req_d == total_words)) begin
                    state_d = BSF_DRAIN;
                end
            end
            BSF_FLUSH: begin
                if (req_fire) begin
                    pend_d = 1'b0;
                end
                if ((outstanding_d == '0) && !(pend_q && !req_fire) && fifo_clear_next) begin
                    state_d = BSF_IDLE;
                end
            end
            default: state_d = BSF_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BSF_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            bytes_sent_q  <= '0;
            words_req_q   <= '0;
            outstanding_q <= '0;
            byte_idx_q    <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            pend_q        <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            len_q         <= len_d;
            bytes_sent_q  <= bytes_sent_d;
            words_req_q   <= words_req_d;
            outstanding_q <= outstanding_d;
            byte_idx_q    <= byte_idx_d;
            done_q        <= done_d;
            error_q       <= error_d;
            pend_q        <= pend_d;
            armed_q       <= armed_d;
        end
    end

endmodule

// File: tb/tb_qdec_bs_fetch_ctrl.sv
// tb/tb_qdec_bs_fetch_ctrl.sv - vector table, random transfers and corner sequences against a memory/stream model
`timescale 1ns/1ps
module tb_qdec_bs_fetch_ctrl;

    logic        clk, rst, start, abort, busy, done, error;
    logic [31:0] base_addr, mem_req_addr, mem_rsp_data;
    logic [16:0] byte_len, bytes_sent;
    logic        mem_req_vld, mem_req_rdy, mem_rsp_vld;
    logic [7:0]  bs_dout;
    logic        bs_dout_vld, bs_dout_rdy;

    qdec_bs_fetch_ctrl #(.ADDR_W(32), .MAX_OUTSTANDING(4), .BUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .byte_len(byte_len),
        .abort(abort), .busy(busy), .done(done), .error(error), .bytes_sent(bytes_sent),
        .mem_req_addr(mem_req_addr), .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_vld(mem_rsp_vld),
        .bs_dout(bs_dout), .bs_dout_vld(bs_dout_vld), .bs_dout_rdy(bs_dout_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] base;
        int          len;
        int          lat;
        bit          bs_rand;
        bit          rq_rand;
        int          stall;
        bit          exp_err;
        bit          exp_done;
        int          exp_reqs;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    int checks = 0;
    int failures = 0;

    rsp_t        rspq[$];
    logic [31:0] req_log[$];
    logic [7:0]  byte_log[$];
    int ncyc = 0, lat = 3, stall = 0, req_limit = 1 << 30;
    int done_cnt = 0, err_cnt = 0, hs_cnt = 0, rsp_cnt = 0;
    int inv_fail = 0, stab_fail = 0, lat_fail = 0, first_rsp_cyc = -10;
    bit bs_rand = 0, rq_rand = 0, inject = 0, lat_arm = 0;
    bit p_bvld, p_brdy, p_rvld, p_rrdy, p_abort;
    logic [7:0]  p_bdat;
    logic [31:0] p_raddr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hA5C3_0F1E;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [31:0] base, input int k);
        logic [31:0] w;
        w = mem_word(base + 32'(4 * (k / 4)));
        return w[8 * (k % 4) +: 8];
    endfunction

    // Memory and stream environment: responses in order after 'lat' cycles, logs every handshake.
    initial begin
        mem_rsp_vld = 1'b0; mem_rsp_data = '0; mem_req_rdy = 1'b0; bs_dout_rdy = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            mem_rsp_vld = 1'b0;
            mem_rsp_data = '0;
            if (inject) begin
                mem_rsp_vld = 1'b1; mem_rsp_data = 32'hDEAD_BEEF; inject = 0;
            end else if (rspq.size() > 0 && rspq[0].due <= ncyc) begin
                mem_rsp_vld = 1'b1;
                mem_rsp_data = mem_word(rspq[0].addr);
                void'(rspq.pop_front());
                rsp_cnt++;
                if (rsp_cnt == 1 && lat_arm) first_rsp_cyc = ncyc;
            end
            mem_req_rdy = (req_log.size() < req_limit) && (rq_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
            if (stall > 0) begin
                bs_dout_rdy = 1'b0;
                stall--;
            end else begin
                bs_dout_rdy = bs_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            #1;
            if (rst) begin
                p_bvld = 0; p_brdy = 0; p_rvld = 0; p_rrdy = 0; p_abort = 0;
            end else begin
                if (p_bvld && !p_brdy && !p_abort && (!bs_dout_vld || bs_dout !== p_bdat)) stab_fail++;
                if (p_rvld && !p_rrdy && (!mem_req_vld || mem_req_addr !== p_raddr)) stab_fail++;
                if (mem_req_vld && mem_req_rdy) begin
                    req_log.push_back(mem_req_addr);
                    rspq.push_back('{mem_req_addr, ncyc + lat});
                    hs_cnt++;
                end
                if (bs_dout_vld && bs_dout_rdy) byte_log.push_back(bs_dout);
                if (done) done_cnt++;
                if (error) err_cnt++;
                if ((hs_cnt - byte_log.size() / 4) > 4) inv_fail++;
                if (lat_arm && ncyc == first_rsp_cyc + 1) begin
                    lat_arm = 0;
                    if (!bs_dout_vld) lat_fail++;
                end
                p_bvld = bs_dout_vld; p_brdy = bs_dout_rdy; p_bdat = bs_dout;
                p_rvld = mem_req_vld; p_rrdy = mem_req_rdy; p_raddr = mem_req_addr; p_abort = abort;
            end
        end
    end

    task automatic clear_logs();
        req_log.delete(); byte_log.delete();
        done_cnt = 0; err_cnt = 0; hs_cnt = 0; rsp_cnt = 0;
        inv_fail = 0; stab_fail = 0; lat_fail = 0; first_rsp_cyc = -10;
    endtask

    task automatic run_xfer(input vec_t v, input string nm);
        int addr_bad, byte_bad;
        clear_logs();
        lat = v.lat; bs_rand = v.bs_rand; rq_rand = v.rq_rand; stall = 0;
        lat_arm = (v.exp_reqs > 0);
        @(negedge clk); #3;
        start = 1; base_addr = v.base; byte_len = 17'(v.len);
        @(negedge clk); #3;
        start = 0;
        check($sformatf("%s.busy_after_start", nm), busy, v.exp_reqs > 0);
        check($sformatf("%s.req_vld_after_start", nm), mem_req_vld, v.exp_reqs > 0);
        check($sformatf("%s.done_after_start", nm), done, v.exp_done && v.exp_reqs == 0);
        check($sformatf("%s.err_after_start", nm), error, v.exp_err);
        if (v.stall > 0) begin
            for (int i = 0; i < 2000 && byte_log.size() < 8; i++) @(negedge clk);
            stall = v.stall;
        end
        for (int i = 0; i < 20000 && busy; i++) @(negedge clk);
        check($sformatf("%s.finished_in_time", nm), busy, 0);
        repeat (v.lat + 4) @(negedge clk);
        addr_bad = 0;
        foreach (req_log[i]) if (req_log[i] !== v.base + 32'(4 * i)) addr_bad++;
        byte_bad = 0;
        foreach (byte_log[i]) if (byte_log[i] !== exp_byte(v.base, i)) byte_bad++;
        check($sformatf("%s.req_count", nm), req_log.size(), v.exp_reqs);
        check($sformatf("%s.req_addrs_bad", nm), addr_bad, 0);
        check($sformatf("%s.byte_count", nm), byte_log.size(), v.exp_reqs > 0 ? v.len : 0);
        check($sformatf("%s.bytes_bad", nm), byte_bad, 0);
        check($sformatf("%s.done_pulses", nm), done_cnt, v.exp_done);
        check($sformatf("%s.error_pulses", nm), err_cnt, v.exp_err);
        if (v.exp_reqs > 0) begin
            check($sformatf("%s.bytes_sent", nm), bytes_sent, v.len);
            check($sformatf("%s.credit_overrun", nm), inv_fail, 0);
            check($sformatf("%s.stability", nm), stab_fail, 0);
            check($sformatf("%s.rsp_to_byte_latency", nm), lat_fail, 0);
        end
    endtask

    vec_t vecs[9];

    initial begin
        int n_at_abort;
        vec_t v;
        rst = 1; start = 0; abort = 0; base_addr = '0; byte_len = '0;

        vecs[0] = '{32'h0000_1000, 10, 3, 0, 0, 0, 0, 1, 3};
        vecs[1] = '{32'h0000_1002, 10, 3, 0, 0, 0, 1, 0, 0};
        vecs[2] = '{32'h0000_2000, 0, 3, 0, 0, 0, 0, 1, 0};
        vecs[3] = '{32'h0000_3000, 1, 1, 0, 0, 0, 0, 1, 1};
        vecs[4] = '{32'h0000_4000, 4, 2, 0, 0, 0, 0, 1, 1};
        vecs[5] = '{32'h0000_5000, 7, 5, 1, 1, 0, 0, 1, 2};
        vecs[6] = '{32'h0000_6000, 64, 3, 0, 0, 20, 0, 1, 16};
        for (int i = 7; i < 9; i++) begin
            vecs[i].base = $urandom & 32'hFFFF_FFFC;
            vecs[i].len = $urandom_range(1, 150);
            vecs[i].lat = $urandom_range(1, 8);
            vecs[i].bs_rand = 1; vecs[i].rq_rand = 1; vecs[i].stall = 0;
            vecs[i].exp_err = 0; vecs[i].exp_done = 1;
            vecs[i].exp_reqs = (vecs[i].len + 3) / 4;
        end

        repeat (3) @(negedge clk);
        #3;
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.error", error, 0);
        check("reset.bytes_sent", bytes_sent, 0);
        check("reset.mem_req_vld", mem_req_vld, 0);
        check("reset.mem_req_addr", mem_req_addr, 0);
        check("reset.bs_dout_vld", bs_dout_vld, 0);
        check("reset.bs_dout", bs_dout, 0);
        rst = 0;

        foreach (vecs[i]) run_xfer(vecs[i], $sformatf("vec%0d", i));

        // Stray response while idle.
        clear_logs();
        @(negedge clk); #3;
        inject = 1;
        repeat (4) @(negedge clk);
        check("proto.error_pulses", err_cnt, 1);
        check("proto.busy", busy, 0);
        check("proto.bytes_sent_held", bytes_sent, vecs[8].len);

        // Abort with three words requested and two still in flight.
        clear_logs();
        lat = 6; bs_rand = 0; rq_rand = 0; req_limit = 3;
        @(negedge clk); #3;
        start = 1; base_addr = 32'h0000_8000; byte_len = 17'd1000;
        @(negedge clk); #3;
        start = 0;
        for (int i = 0; i < 200 && !(req_log.size() == 3 && rsp_cnt == 1); i++) begin
            @(negedge clk); #3;
        end
        check("abort.reached_point", (req_log.size() == 3 && rsp_cnt == 1), 1);
        n_at_abort = req_log.size();
        check("abort.next_req_presented", mem_req_vld, 1);
        abort = 1;
        @(negedge clk); #3;
        abort = 0;
        req_limit = 1 << 30;
        check("abort.bs_vld_dropped", bs_dout_vld, 0);
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("abort.busy_fell", busy, 0);
        check("abort.late_rsps_pending", rspq.size(), 0);
        repeat (10) @(negedge clk);
        check("abort.req_count", req_log.size(), n_at_abort + 1);
        check("abort.done_pulses", done_cnt, 0);
        check("abort.error_pulses", err_cnt, 0);
        check("abort.stability", stab_fail, 0);

        // Asynchronous reset while draining.
        clear_logs();
        lat = 4; bs_rand = 1; rq_rand = 0;
        @(negedge clk); #3;
        start = 1; base_addr = 32'h0000_9000; byte_len = 17'd40;
        @(negedge clk); #3;
        start = 0;
        for (int i = 0; i < 500 && !(req_log.size() == 10 && byte_log.size() >= 2); i++) @(negedge clk);
        check("rst.reached_drain", (req_log.size() == 10 && busy), 1);
        @(negedge clk); #3;
        rst = 1;
        #1;
        check("rst.busy_now", busy, 0);
        check("rst.bs_vld_now", bs_dout_vld, 0);
        check("rst.req_vld_now", mem_req_vld, 0);
        check("rst.bytes_sent_now", bytes_sent, 0);
        repeat (2) @(negedge clk);
        #3;
        rst = 0;
        err_cnt = 0;
        for (int i = 0; i < 200 && rspq.size() > 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("rst.late_rsp_no_error", err_cnt, 0);
        check("rst.idle_after", busy, 0);
        v = '{32'h0000_A000, 20, 2, 0, 0, 0, 0, 1, 5};
        run_xfer(v, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
